// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word access to a word memory with range, funct3 and alignment checking.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses; otherwise the low address bits are forced to natural alignment.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_add,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        err_q;

  logic        f3_legal;
  logic        req_half;
  logic        req_word;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] aligned_addr;

  always_comb begin
    f3_legal     = 1'b0;
    req_half     = (req_funct3[1:0] == 2'b01);
    req_word     = (req_funct3[1:0] == 2'b10);
    aligned_addr = req_addr;
    misaligned   = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_we;
      default:                f3_legal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (req_half && req_addr[0]) || (req_word && (req_addr[1:0] != 2'b00));
`else
    if (req_half) aligned_addr[0] = 1'b0;
    if (req_word) aligned_addr[1:0] = 2'b00;
`endif
    out_of_range = (aligned_addr[31:2] >= WORD_LIMIT);
    req_err      = !f3_legal || out_of_range || misaligned;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      word_q   <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= aligned_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            err_q    <= req_err;
            if (req_err)                state <= RESP;
            else if (req_we && req_word) state <= WRITE;
            else                         state <= READ;
          end
        end
        READ: begin
          word_q <= mem_read_data;
          state  <= we_q ? WRITE : RESP;
        end
        WRITE:   state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  // Sub-word stores are read-modify-write: only the addressed lane of word_q is replaced.
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  always_comb begin
    merged = word_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = word_q[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = word_q;
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = 32'd0;
    endcase
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    req_ready        = (state == IDLE);
    resp_valid       = (state == RESP);
    resp_err         = (state == RESP) && err_q;
    resp_rdata       = ((state == RESP) && !we_q && !err_q) ? load_val : 32'd0;
    mem_add          = ((state == READ) || (state == WRITE)) ? {2'b00, addr_q[31:2]} : 32'd0;
    mem_write_enable = (state == WRITE);
    mem_write_data   = (state == WRITE) ? merged : 32'd0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized requests checked against a behavioural model of memory and responses.
module tb_load_store_unit;
  localparam int MEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_add;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_add(mem_add), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  assign mem_read_data = mem[mem_add[4:0]];

  // Memory commits on the falling edge of the strobe cycle.
  always @(negedge clk) if (mem_write_enable) mem[mem_add[4:0]] = mem_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  lat;
    logic [1:0]  strobes;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   strobe_cnt = 0;
  logic [31:0] word1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed view of memory with the RV32I width rules.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int size, off, idx;
    logic legal, bad;
    logic [31:0] w, v;
    e = '{rdata: 32'd0, err: 1'b1, lat: 2'd1, strobes: 2'd0};
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(addr % 4);
    bad   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    bad = legal && ((off % size) != 0);
`else
    off = off - (off % size);
`endif
    if (!legal || bad || ((addr >> 2) >= MEM_WORDS)) return e;
    idx = int'(addr >> 2);
    w = ref_mem[idx];
    e.err = 1'b0;
    if (we) begin
      if (size == 4) w = wd;
      else for (int k = 0; k < size; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
      ref_mem[idx] = w;
      e.lat = (size == 4) ? 2'd2 : 2'd3;
      e.strobes = 2'd1;
    end else begin
      v = w >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3[2] == 1'b0 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3[2] == 1'b0 && v[15]) v = v | 32'hFFFF_0000;
      end
      e.rdata = v;
      e.lat = 2'd2;
    end
    return e;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit use_exp, input exp_t ex);
    exp_t m;
    int n;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fails++; tests++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    m = model(we, f3, addr, wd);
    sb.push_back(use_exp ? ex : m);
    acc_q.push_back(cyc);
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fails++; tests++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete(); acc_q.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    int a;
    forever begin
      @(negedge clk);
      if (reset) begin
        strobe_cnt = 0;
        continue;
      end
      if (mem_write_enable) strobe_cnt++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          fails++; tests++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          e = sb.pop_front();
          a = acc_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("latency", 32'(cyc - a + 1), 32'(e.lat));
          chk("write_strobes", 32'(strobe_cnt), 32'(e.strobes));
        end
        strobe_cnt = 0;
      end
    end
  end

  logic [2:0] f3_tab [14] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd2, 3'd0};

  initial begin : stim
    exp_t ex;
    logic [31:0] a, wd;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[3] = 32'h8899AABB;
    mem[4] = 32'h8001FFFF;
    mem[5] = 32'h12345678;
    word1 = mem[1];
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = mem[i];

    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_add", mem_add, 32'd0);
    chk("rst_mem_write_data", mem_write_data, 32'd0);
    chk("rst_mem_write_enable", 32'(mem_write_enable), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    ex = '{rdata: 32'hFFFFFFAA, err: 1'b0, lat: 2'd2, strobes: 2'd0};
    issue(1'b0, 3'b000, 32'h0000000D, 32'd0, 1'b1, ex);
    ex = '{rdata: 32'd0, err: 1'b0, lat: 2'd3, strobes: 2'd1};
    issue(1'b1, 3'b000, 32'h0000000E, 32'h000000CC, 1'b1, ex);
    ex = '{rdata: 32'h00008001, err: 1'b0, lat: 2'd2, strobes: 2'd0};
    issue(1'b0, 3'b101, 32'h00000012, 32'd0, 1'b1, ex);
`ifdef LSU_MISALIGN_TRAP_EN
    ex = '{rdata: 32'd0, err: 1'b1, lat: 2'd1, strobes: 2'd0};
`else
    ex = '{rdata: word1, err: 1'b0, lat: 2'd2, strobes: 2'd0};
`endif
    issue(1'b0, 3'b010, 32'h00000006, 32'd0, 1'b1, ex);
    ex = '{rdata: 32'd0, err: 1'b1, lat: 2'd1, strobes: 2'd0};
    issue(1'b1, 3'b010, 32'h00000080, 32'hFFFFFFFF, 1'b1, ex);
    drain();
    chk("sb_word3", mem[3], 32'h88CCAABB);

    for (int t = 0; t < 300; t++) begin
      a = 32'($urandom_range(0, 4 * MEM_WORDS + 15));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      wd = $urandom;
      issue(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 13)], a, wd, 1'b0, ex);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();

    // Reset in the middle of a word store: strobe must drop at once and nothing is reported.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h00000014; req_wdata = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_rst_strobe_before", 32'(mem_write_enable), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_strobe_drop", 32'(mem_write_enable), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_word5", mem[5], ref_mem[5]);

    // First acceptance on the first edge after reset release.
    issue(1'b0, 3'b010, 32'h00000014, 32'd0, 1'b0, ex);
    chk("first_accept_busy", 32'(req_ready), 32'd0);
    repeat (4) begin
      a = 32'($urandom_range(0, 4 * MEM_WORDS - 1));
      issue(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 9)], a, $urandom, 1'b0, ex);
    end
    drain();

    for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, 32, number of 32-bit words in the attached data memory; legal word index range is 0..MEM_WORDS-1.
REQ-002 Ports; clock and reset first:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended to 32 bits.
- resp_err  out  1  request rejected; qualified by resp_valid.
- mem_add  out  32  word index to memory.
- mem_write_data  out  32  memory write word.
- mem_write_enable  out  1  memory write strobe.
- mem_read_data  in  32  combinational memory read of mem_add.

Function
REQ-003 Handshake: a request is accepted on a rising edge with req_valid=1 and req_ready=1; req_ready=1 only in IDLE; request fields are captured at acceptance.
REQ-004 FSM states and transitions:
- IDLE, READ, WRITE, RESP.
- IDLE->READ on an accepted load, SB or SH.
- IDLE->WRITE on an accepted SW.
- IDLE->RESP on an error request.
- READ->RESP for a load.
- READ->WRITE for SB/SH.
- WRITE->RESP.
- RESP->IDLE unconditionally.
REQ-005 mem_add = {2'b00, addr[31:2]} from the captured address in READ and WRITE; mem_add=0 in IDLE and RESP.
REQ-006 READ captures mem_read_data into an internal word register at the end of the cycle.
REQ-007 SW: WRITE drives mem_write_data=wdata.
REQ-008 SB: WRITE drives the captured word with byte lane addr[1:0] replaced by wdata[7:0]. SH: WRITE drives the captured word with half lane addr[1] replaced by wdata[15:0]. No other lanes are altered.
REQ-009 mem_write_enable=1 in WRITE only, for exactly one cycle per store; it is never asserted for loads or for errors.
REQ-010 Load extraction:
- LB/LH select the lane by addr[1:0] / addr[1] and sign-extend.
- LBU/LHU select the same lane and zero-extend.
- LW passes the word through.
REQ-011 RESP asserts resp_valid=1 for one cycle. resp_rdata is valid for loads and is 0 for stores and errors.
REQ-012 Latency from acceptance edge to the resp_valid cycle:
- LB/LH/LW/LBU/LHU: 2 cycles.
- SW: 2 cycles.
- SB/SH: 3 cycles.
- error: 1 cycle.
REQ-013 Error conditions, all routed to RESP with resp_err=1 and no memory access:
- funct3 not in the legal set (including 100/101 with req_we=1);
- word index >= MEM_WORDS;
- misalignment, per REQ-019.
REQ-014 Back-to-back: the next request is accepted no earlier than the edge following the RESP cycle; req_valid held during busy states is ignored.

Reset
REQ-015 reset=1 forces IDLE asynchronously, regardless of clk.
REQ-016 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_add=0, mem_write_data=0, mem_write_enable=0.
REQ-017 Reset mid-operation abandons the request with no response; reset asserted during WRITE deasserts mem_write_enable immediately.
REQ-018 The first acceptance is possible on the first rising edge after reset deasserts.

Configuration
REQ-019 Macro LSU_MISALIGN_TRAP_EN:
- Defined: halfword access with addr[0]=1 and word access with addr[1:0]!=0 are errors (REQ-013).
- Undefined: those low bits are forced to zero (natural alignment), the access proceeds, and misalignment never sets resp_err; funct3 and range errors remain.

Verification
REQ-020 Memory word 3 = 32'h8899AABB; LB addr 32'h0000000D -> resp_rdata=32'hFFFFFFAA, resp_err=0, resp_valid 2 cycles after acceptance.
REQ-021 SB addr 32'h0000000E wdata 32'h000000CC over word 3 = 32'h8899AABB -> one write strobe, word 3 = 32'h88CCAABB, response 3 cycles after acceptance.
REQ-022 LHU addr 32'h00000012 with word 4 = 32'h8001FFFF -> resp_rdata=32'h00008001.
REQ-023 LW addr 32'h00000006:
- with LSU_MISALIGN_TRAP_EN -> resp_err=1, no memory access, response 1 cycle after acceptance;
- without it -> returns word 1.
REQ-024 SW addr 32'h00000080 (word 32) -> resp_err=1, mem_write_enable never asserted.
REQ-025 SW word 5 = 32'h12345678; assert reset during the WRITE cycle -> mem_write_enable drops immediately, no resp_valid, req_ready=1.
